// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encodings and default bus widths,
// used by the APB master and the register-file completer.
package apb_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    // Counter width able to hold values 0..limit; never narrower than one bit.
    function automatic int cnt_width(input int limit);
        if (limit < 2)
            return 1;
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// ACCESS-phase wait-state counter; flags expiry on the wait cycle that
// brings the count up to the configured limit (limit of 0 never expires).
module apb_timeout_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             pclk,
    input  logic             preset_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] limit,
    output logic             expired
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable)
            count <= count + 1'b1;
    end

    assign expired = enable && (limit != '0) && (count == limit - 1'b1);

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB requester: takes one command, runs SETUP/ACCESS
// with optional wait-state timeout, and holds the response until consumed.
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              pclk,
    input  logic              preset_n,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,

    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    localparam int CNT_W = cnt_width(TIMEOUT_CYC);

    logic [1:0] state;
    logic       to_expired;

    assign cmd_ready = (state == ST_IDLE);

    apb_timeout_cnt #(
        .CNT_W (CNT_W)
    ) u_timeout (
        .pclk     (pclk),
        .preset_n (preset_n),
        .clear    (state == ST_SETUP),
        .enable   ((state == ST_ACCESS) && !pready),
        .limit    (CNT_W'(TIMEOUT_CYC)),
        .expired  (to_expired)
    );

    // A ready completer always takes priority over a timeout in the same cycle.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state       <= ST_IDLE;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        pwrite <= cmd_write;
                        paddr  <= cmd_addr;
                        pwdata <= cmd_wdata;
                        psel   <= 1'b1;
                        state  <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    penable <= 1'b1;
                    state   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (pready) begin
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= pwrite ? '0 : prdata;
                        rsp_err     <= pslverr;
                        rsp_timeout <= 1'b0;
                        state       <= ST_RESP;
                    end else if (to_expired) begin
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= '0;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        state       <= ST_RESP;
                    end
                end
                default: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
